// File: rtl/sort_hw_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: sequences JTAG debug commands and CPU Avalon accesses
// onto one single-port RAM, round-robin on contention.
module sort_hw_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter  int unsigned ADDR_W = 8,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned JDO_W  = 38
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned PTR_LSB  = 17;
  localparam int unsigned DATA_LSB = 3;

  typedef enum logic [1:0] {IDLE, ACC, CAP, DONE} state_t;

  state_t              state, state_d;
  logic                cpu_req_c, grant_c, sel_jtag_c, grant_we_c, jtag_done_c, strobe_any_c;
  logic                gnt_jtag, cur_we, last_cpu;
  logic                pend_valid, pend_we;
  logic [DATA_W-1:0]   pend_wdata;
  logic [ADDR_W-1:0]   ptr;
  logic                ram_en_d, ram_we_d, cpu_waitrequest_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d, mon_d, cpu_rdata_d;
  logic                unused_jdo;

  assign cpu_req_c    = cpu_read | cpu_write;
  assign jtag_done_c  = (state == DONE) && gnt_jtag;
  assign strobe_any_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo   = ^{jdo[JDO_W-1:36], jdo[2:0]};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next state and grant decision; last_cpu set means JTAG wins a tie
  always_comb begin
    state_d    = state;
    grant_c    = 1'b0;
    sel_jtag_c = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid || cpu_req_c) begin
          grant_c    = 1'b1;
          sel_jtag_c = pend_valid && (!cpu_req_c || last_cpu);
          state_d    = ACC;
        end
      end
      ACC:     state_d = cur_we ? DONE : CAP;
      CAP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    grant_we_c        = sel_jtag_c ? pend_we : cpu_write;
    ram_en_d          = grant_c;
    ram_we_d          = grant_c && grant_we_c;
    ram_addr_d        = ram_addr;
    ram_wdata_d       = ram_wdata;
    cpu_waitrequest_d = !((state_d == DONE) && !gnt_jtag);
    mon_d             = MonDReg;
    cpu_rdata_d       = cpu_readdata;
    if (grant_c) begin
      ram_addr_d  = sel_jtag_c ? ptr : cpu_address;
      ram_wdata_d = sel_jtag_c ? pend_wdata : cpu_writedata;
    end
    if (state == CAP) begin
      if (gnt_jtag) mon_d       = ram_rdata;
      else          cpu_rdata_d = ram_rdata;
    end
  end

  // Output and grant bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_en          <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      MonDReg         <= '0;
      cpu_readdata    <= '0;
      cpu_waitrequest <= 1'b1;
      gnt_jtag        <= 1'b0;
      cur_we          <= 1'b0;
      last_cpu        <= 1'b1;
    end else begin
      ram_en          <= ram_en_d;
      ram_we          <= ram_we_d;
      ram_addr        <= ram_addr_d;
      ram_wdata       <= ram_wdata_d;
      MonDReg         <= mon_d;
      cpu_readdata    <= cpu_rdata_d;
      cpu_waitrequest <= cpu_waitrequest_d;
      if (grant_c) begin
        gnt_jtag <= sel_jtag_c;
        cur_we   <= grant_we_c;
        last_cpu <= !sel_jtag_c;
      end
    end
  end

  // JTAG command intake, pending slot, pointer and overrun tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_we      <= 1'b0;
      pend_wdata   <= '0;
      ptr          <= '0;
      jtag_busy    <= 1'b0;
      jtag_overrun <= 1'b0;
    end else begin
      if (grant_c && sel_jtag_c) pend_valid <= 1'b0;
      if (jtag_done_c) begin
        jtag_busy <= 1'b0;
        ptr       <= ptr + ADDR_W'(1);
      end
      if (jtag_busy) begin
        if (strobe_any_c) jtag_overrun <= 1'b1;
      end else if (take_action_ocimem_a) begin
        ptr <= jdo[PTR_LSB +: ADDR_W];
        if (jdo[35]) jtag_overrun <= 1'b0;
        if (take_action_ocimem_b || take_no_action_ocimem_a) jtag_overrun <= 1'b1;
        if (jdo[34]) begin
          pend_valid <= 1'b1;
          pend_we    <= 1'b0;
          jtag_busy  <= 1'b1;
        end
      end else if (take_action_ocimem_b) begin
        pend_valid <= 1'b1;
        pend_we    <= 1'b1;
        pend_wdata <= jdo[DATA_LSB +: DATA_W];
        jtag_busy  <= 1'b1;
        if (take_no_action_ocimem_a) jtag_overrun <= 1'b1;
      end else if (take_no_action_ocimem_a) begin
        pend_valid <= 1'b1;
        pend_we    <= 1'b0;
        jtag_busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sort_hw_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Directed scoreboard bench for the OCI memory arbiter with a behavioural RAM.
module tb_sort_hw_nios2_gen2_0_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_waitrequest;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [256];
  logic [31:0] jq[$];
  logic [31:0] cq[$];
  logic [7:0]  acc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sort_hw_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .jdo(jdo), .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));

  // Single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Log of RAM access addresses, used to observe grant order
  always @(negedge clk) if (ram_en) acc_q.push_back(ram_addr);

  function automatic logic [37:0] jaddr(input logic rd, input logic clr, input logic [7:0] a);
    logic [37:0] j;
    j = '0; j[35] = clr; j[34] = rd; j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdata(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Drive a strobe in the current cycle; returns at the next negedge
  task automatic jstrobe(input logic a, input logic b, input logic n, input logic [37:0] j);
    take_action_ocimem_a = a; take_action_ocimem_b = b; take_no_action_ocimem_a = n; jdo = j;
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
  endtask

  // Count busy cycles starting at strobe cycle 1
  task automatic jwait(input string tag, input int exp_cyc);
    int n = 0;
    while (jtag_busy && n < 50) begin n++; @(negedge clk); end
    chk(tag, 32'(n), 32'(exp_cyc));
  endtask

  task automatic jread(input string tag, input logic use_a, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] e;
    jq.push_back(exp);
    if (use_a) jstrobe(1'b1, 1'b0, 1'b0, jaddr(1'b1, 1'b0, a));
    else       jstrobe(1'b0, 1'b0, 1'b1, '0);
    jwait({tag, "_busy_cycles"}, 4);
    e = jq.pop_front();
    chk({tag, "_MonDReg"}, MonDReg, e);
  endtask

  task automatic cpu_access(input string tag, input logic we, input logic [7:0] a,
                            input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
    int k = 0;
    logic [31:0] e;
    cpu_address = a; cpu_write = we; cpu_read = !we; cpu_writedata = d;
    if (!we) cq.push_back(exp);
    while (cpu_waitrequest && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    if (!we) begin
      e = cq.pop_front();
      chk({tag, "_readdata"}, cpu_readdata, e);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    chk({tag, "_waitreq_back_high"}, 32'(cpu_waitrequest), 32'd1);
  endtask

  // JTAG no_action and CPU read both pending in the same IDLE cycle
  task automatic contend(input string tag, input logic [7:0] ca, input logic [31:0] ej, input logic [31:0] ec);
    int  cyc = 0;
    bit  cdone = 0, jdone = 0;
    logic [31:0] e;
    jq.push_back(ej);
    cq.push_back(ec);
    jstrobe(1'b0, 1'b0, 1'b1, '0);
    cpu_address = ca; cpu_read = 1'b1; cpu_write = 1'b0;
    while (!(cdone && jdone) && cyc < 40) begin
      if (!cdone && !cpu_waitrequest) begin
        cdone = 1;
        chk({tag, "_cpu_latency"}, 32'(cyc), 32'd7);
        e = cq.pop_front();
        chk({tag, "_cpu_readdata"}, cpu_readdata, e);
        cpu_read = 1'b0;
      end
      if (!jdone && !jtag_busy) begin
        jdone = 1;
        e = jq.pop_front();
        chk({tag, "_jtag_MonDReg"}, MonDReg, e);
      end
      @(negedge clk); cyc++;
    end
    chk({tag, "_both_done"}, {30'd0, cdone, jdone}, 32'd3);
  endtask

  initial begin
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    jdo = '0; cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
    repeat (2) @(negedge clk);
    chk("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
    chk("rst_ram_en", {30'd0, ram_en, ram_we}, 32'd0);
    chk("rst_MonDReg", MonDReg, 32'd0);
    chk("rst_readdata", cpu_readdata, 32'd0);
    chk("rst_busy_ovr", {30'd0, jtag_busy, jtag_overrun}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // JTAG write, wrap and readback
    jstrobe(1'b1, 1'b0, 1'b0, jaddr(1'b0, 1'b0, 8'hFE));
    chk("addr_only_busy", {30'd0, jtag_busy, jtag_overrun}, 32'd0);
    jstrobe(1'b0, 1'b1, 1'b0, jdata(32'hDEADBEEF));
    jwait("jwr0_busy_cycles", 3);
    jstrobe(1'b0, 1'b1, 1'b0, jdata(32'h12345678));
    jwait("jwr1_busy_cycles", 3);
    jread("jrd_fe", 1'b1, 8'hFE, 32'hDEADBEEF);
    jread("jrd_ff", 1'b0, 8'h00, 32'h12345678);
    jread("jrd_wrap00", 1'b0, 8'h00, pat(8'h00));

    // CPU alone
    cpu_access("cpu_wr", 1'b1, 8'h10, 32'hA5A5A5A5, 32'h0, 2);
    cpu_access("cpu_rd", 1'b0, 8'h10, 32'h0, 32'hA5A5A5A5, 3);

    // Contention, twice; expected grant order JTAG, CPU, JTAG, CPU
    jstrobe(1'b1, 1'b0, 1'b0, jaddr(1'b0, 1'b0, 8'h20));
    acc_q.delete();
    contend("cont0", 8'h40, pat(8'h20), pat(8'h40));
    contend("cont1", 8'h41, pat(8'h21), pat(8'h41));
    chk("grant_log_len", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() == 4) begin
      chk("grant0_jtag", 32'(acc_q[0]), 32'h20);
      chk("grant1_cpu",  32'(acc_q[1]), 32'h40);
      chk("grant2_jtag", 32'(acc_q[2]), 32'h21);
      chk("grant3_cpu",  32'(acc_q[3]), 32'h41);
    end

    // Overrun: strobe while busy is dropped, ptr advances once
    jstrobe(1'b1, 1'b0, 1'b0, jaddr(1'b0, 1'b0, 8'h30));
    jstrobe(1'b0, 1'b1, 1'b0, jdata(32'hCAFEF00D));
    @(negedge clk);
    jstrobe(1'b0, 1'b0, 1'b1, '0);
    chk("ovr_set", 32'(jtag_overrun), 32'd1);
    jwait("ovr_write_busy_left", 1);
    jread("ovr_rd_ptr31", 1'b0, 8'h00, pat(8'h31));
    jstrobe(1'b1, 1'b0, 1'b0, jaddr(1'b0, 1'b1, 8'h30));
    chk("ovr_clear", 32'(jtag_overrun), 32'd0);
    jread("ovr_wr_at30", 1'b1, 8'h30, 32'hCAFEF00D);

    // Simultaneous ocimem_a and ocimem_b: address load only
    jstrobe(1'b1, 1'b1, 1'b0, jaddr(1'b0, 1'b0, 8'h50));
    chk("simul_ovr_busy", {30'd0, jtag_busy, jtag_overrun}, 32'd1);
    jread("simul_rd50", 1'b0, 8'h00, pat(8'h50));

    // Reset in the middle of a JTAG read
    jstrobe(1'b0, 1'b0, 1'b1, '0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_waitreq", 32'(cpu_waitrequest), 32'd1);
    chk("midrst_MonDReg", MonDReg, 32'd0);
    chk("midrst_busy_ovr", {30'd0, jtag_busy, jtag_overrun}, 32'd0);
    chk("midrst_ram_en", 32'(ram_en), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    cpu_access("postrst_wr", 1'b1, 8'h60, 32'h11112222, 32'h0, 2);
    jread("postrst_ptr0", 1'b0, 8'h00, pat(8'h00));
    cpu_access("postrst_rd", 1'b0, 8'h60, 32'h0, 32'h11112222, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
